// File: rtl/fp_round_norm_ctrl_if.sv
// Operand and result handshake bundle for the FP32 round/normalise sequencer.
// The master drives operands and out_ready. The slave (the sequencer) drives in_ready and the result.
interface fp_round_norm_ctrl_if #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [MANT_W:0]   in_mant;
    logic [2:0]        in_grs;

    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [EXP_W-1:0]  out_exp;
    logic [MANT_W-1:0] out_mant;
    logic              out_ovf;
    logic              out_special;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_grs, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_mant, out_ovf, out_special
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_grs, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_mant, out_ovf, out_special
    );
endinterface

// File: rtl/fp_round_norm_ctrl.sv
// Round-to-nearest-even and renormalisation sequencer for the FP32 datapath.
// Handles one operation at a time: IDLE -> ROUND -> ADJUST -> DONE, and a bypass for exponent 8'hFF.

module controlled_inc #(
    parameter int W = 8
) (
    input  logic         a,
    input  logic [W-1:0] d,
    output logic [W-1:0] z
);
    assign z = d + {{(W-1){1'b0}}, a};
endmodule

module fp_round_norm_ctrl #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fp_round_norm_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUND  = 2'd1,
        ADJUST = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [EXP_W-1:0] EXP_MAX  = '1;
    localparam logic [EXP_W-1:0] EXP_LAST = {{(EXP_W-1){1'b1}}, 1'b0};

    state_t state;
    state_t state_nx;

    // captured operand and working registers
    logic              sign_q;
    logic [EXP_W-1:0]  exp_q;
    logic [MANT_W:0]   mant_q;
    logic [2:0]        grs_q;
    logic [MANT_W+1:0] mant25_q;
    logic              special_q;
    logic              ovf_q;

    // registered result
    logic              out_valid_q;
    logic              out_sign_q;
    logic [EXP_W-1:0]  out_exp_q;
    logic [MANT_W-1:0] out_mant_q;
    logic              out_ovf_q;
    logic              out_special_q;

    logic              in_ready_c;
    logic              inc_en;
    logic              round_up;
    logic [EXP_W-1:0]  inc_z;

    controlled_inc #(.W(EXP_W)) u_inc (
        .a (inc_en),
        .d (exp_q),
        .z (inc_z)
    );

    // guard set and (round | sticky | lsb): nearest, ties to even
    assign round_up = grs_q[2] & (grs_q[1] | grs_q[0] | mant_q[0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        in_ready_c = 1'b0;
        inc_en     = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_nx = (bus.in_exp == EXP_MAX) ? DONE : ROUND;
                end
            end
            ROUND: begin
                state_nx = ADJUST;
            end
            ADJUST: begin
                // carry-out renormalises; a denormal that rounded into the hidden bit becomes normal
                inc_en   = mant25_q[MANT_W+1] | ((exp_q == '0) & mant25_q[MANT_W]);
                state_nx = DONE;
            end
            DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_q        <= 1'b0;
            exp_q         <= '0;
            mant_q        <= '0;
            grs_q         <= '0;
            mant25_q      <= '0;
            special_q     <= 1'b0;
            ovf_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            out_sign_q    <= 1'b0;
            out_exp_q     <= '0;
            out_mant_q    <= '0;
            out_ovf_q     <= 1'b0;
            out_special_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_q    <= bus.in_sign;
                        exp_q     <= bus.in_exp;
                        mant_q    <= bus.in_mant;
                        grs_q     <= bus.in_grs;
                        special_q <= (bus.in_exp == EXP_MAX);
                        ovf_q     <= 1'b0;
                    end
                end
                ROUND: begin
                    mant25_q <= {1'b0, mant_q} + {{(MANT_W+1){1'b0}}, round_up};
                end
                ADJUST: begin
                    exp_q <= inc_z;
                    ovf_q <= inc_en && (exp_q == EXP_LAST);
                    if (mant25_q[MANT_W+1]) begin
                        mant25_q <= mant25_q >> 1;
                    end
                end
                DONE: begin
                    // result is loaded on the first DONE cycle, so out_valid rises one edge later
                    if (!out_valid_q) begin
                        out_valid_q   <= 1'b1;
                        out_sign_q    <= sign_q;
                        out_exp_q     <= exp_q;
                        out_ovf_q     <= ovf_q;
                        out_special_q <= special_q;
                        if (special_q) begin
                            out_mant_q <= mant_q[MANT_W-1:0];
                        end else if (ovf_q) begin
                            out_mant_q <= '0;
                        end else begin
                            out_mant_q <= mant25_q[MANT_W-1:0];
                        end
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_sign    = out_sign_q;
    assign bus.out_exp     = out_exp_q;
    assign bus.out_mant    = out_mant_q;
    assign bus.out_ovf     = out_ovf_q;
    assign bus.out_special = out_special_q;

endmodule
